// File: rtl/fifo_16i_64o_pkg.sv
// Shared constants and types for the 16-bit-in / 64-bit-out width-converting FIFO.
package fifo_16i_64o_pkg;

   localparam int WR_DEPTH_WIDTH   = 10;
   localparam int WR_DATA_WIDTH    = 16;
   localparam int RD_DEPTH_WIDTH   = 8;
   localparam int RD_DATA_WIDTH    = 64;
   localparam int RATIO            = 4;
   localparam int LANE_SEL_W       = 2;
   localparam int ALMOST_FULL_NUM  = 1020;
   localparam int ALMOST_EMPTY_NUM = 4;

   typedef struct packed {
      logic wr_full;
      logic almost_full;
      logic rd_empty;
      logic almost_empty;
   } fifo_flags_t;

   localparam fifo_flags_t FLAGS_RST = '{wr_full: 1'b0, almost_full: 1'b0,
                                         rd_empty: 1'b1, almost_empty: 1'b1};

endpackage

// File: rtl/fifo_ram_16w_64r.sv
// Simple dual-port RAM: 16-bit lane writes, synchronous 64-bit reads.
// Each lane is its own narrow array so the lane write enables stay independent.
// The read register is the FIFO's rd_data register; it resets, the arrays do not.
module fifo_ram_16w_64r
   import fifo_16i_64o_pkg::*;
#(
   parameter int ADDR_W = RD_DEPTH_WIDTH,
   parameter int LANE_W = WR_DATA_WIDTH,
   parameter int LANES  = RATIO,
   parameter int SEL_W  = LANE_SEL_W
) (
   input  logic                         wr_clk,
   input  logic                         rd_clk,
   input  logic                         rst,
   input  logic                         wr_en,
   input  logic [SEL_W-1:0]             wr_lane,
   input  logic [ADDR_W-1:0]            wr_addr,
   input  logic [LANE_W-1:0]            wr_data,
   input  logic                         rd_en,
   input  logic [ADDR_W-1:0]            rd_addr,
   output logic [LANES-1:0][LANE_W-1:0] rd_data
);

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [LANE_W-1:0] mem_q [2**ADDR_W];
      logic [LANE_W-1:0] rd_q;

      // lane write: only the lane selected by the low write-pointer bits
      always_ff @(posedge wr_clk) begin
         if (wr_en && (wr_lane == SEL_W'(l))) begin
            mem_q[wr_addr] <= wr_data;
         end
      end

      // synchronous read; holds its value when no read is accepted
      always_ff @(posedge rd_clk or posedge rst) begin
         if (rst) begin
            rd_q <= '0;
         end else if (rd_en) begin
            rd_q <= mem_q[rd_addr];
         end
      end

      assign rd_data[l] = rd_q;
   end

endmodule

// File: rtl/fifo_16i_64o_w1024.sv
// Width-converting FIFO, 1024 x 16 in, 256 x 64 out, single clock domain.
// W = wr_ptr - 4*rd_ptr (mod 2048) is the stored count in write words; the
// extra wrap bit on each pointer separates full (1024) from empty (0).
module fifo_16i_64o_w1024
   import fifo_16i_64o_pkg::*;
(
   input  logic                      wr_clk,
   input  logic                      wr_rst,
   input  logic                      rd_clk,
   input  logic                      rd_rst,
   input  logic [WR_DATA_WIDTH-1:0]  wr_data,
   input  logic                      wr_en,
   output logic                      wr_full,
   output logic [WR_DEPTH_WIDTH:0]   wr_water_level,
   output logic                      almost_full,
   output logic [RD_DATA_WIDTH-1:0]  rd_data,
   input  logic                      rd_en,
   output logic                      rd_empty,
   output logic [RD_DEPTH_WIDTH:0]   rd_water_level,
   output logic                      almost_empty
);

   localparam int WR_PTR_W = WR_DEPTH_WIDTH + 1;
   localparam int RD_PTR_W = RD_DEPTH_WIDTH + 1;

   localparam logic [WR_PTR_W-1:0] WR_ONE   = WR_PTR_W'(1);
   localparam logic [RD_PTR_W-1:0] RD_ONE   = RD_PTR_W'(1);
   localparam logic [WR_PTR_W-1:0] FULL_LVL = WR_PTR_W'(1 << WR_DEPTH_WIDTH);
   localparam logic [WR_PTR_W-1:0] AF_LVL   = WR_PTR_W'(ALMOST_FULL_NUM);
   localparam logic [RD_PTR_W-1:0] AE_LVL   = RD_PTR_W'(ALMOST_EMPTY_NUM);

   logic                rst;
   logic                wr_accept;
   logic                rd_accept;
   logic [WR_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [RD_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [WR_PTR_W-1:0] wr_lvl_q, wr_lvl_d;
   logic [RD_PTR_W-1:0] rd_lvl_q, rd_lvl_d;
   fifo_flags_t         flags_q, flags_d;
   logic [RD_DATA_WIDTH-1:0] ram_rd_data;

   // both resets clear the whole block; the two sides never run independently
   assign rst = wr_rst | rd_rst;

   // requests are qualified by the registered flags, which are always current
   assign wr_accept = wr_en & ~flags_q.wr_full;
   assign rd_accept = rd_en & ~flags_q.rd_empty;

   // next pointers, then level and flags derived from the next pointers
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      flags_d  = FLAGS_RST;
      if (wr_accept) begin
         wr_ptr_d = wr_ptr_q + WR_ONE;
      end
      if (rd_accept) begin
         rd_ptr_d = rd_ptr_q + RD_ONE;
      end
      wr_lvl_d = wr_ptr_d - {rd_ptr_d, {LANE_SEL_W{1'b0}}};
      rd_lvl_d = wr_lvl_d[WR_PTR_W-1:LANE_SEL_W];
      flags_d.wr_full      = (wr_lvl_d == FULL_LVL);
      flags_d.almost_full  = (wr_lvl_d >= AF_LVL);
      flags_d.rd_empty     = (rd_lvl_d == '0);
      flags_d.almost_empty = (rd_lvl_d <= AE_LVL);
   end

   // pointer, level and flag registers
   always_ff @(posedge wr_clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         wr_lvl_q <= '0;
         rd_lvl_q <= '0;
         flags_q  <= FLAGS_RST;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         wr_lvl_q <= wr_lvl_d;
         rd_lvl_q <= rd_lvl_d;
         flags_q  <= flags_d;
      end
   end

   // A read word and the word being filled can share an address only at
   // W in 0..3 or W == 1024, where the read or the write is blocked, so the
   // synchronous read never races the lane writes.
   fifo_ram_16w_64r u_ram (
      .wr_clk  (wr_clk),
      .rd_clk  (rd_clk),
      .rst     (rst),
      .wr_en   (wr_accept),
      .wr_lane (wr_ptr_q[LANE_SEL_W-1:0]),
      .wr_addr (wr_ptr_q[WR_DEPTH_WIDTH-1:LANE_SEL_W]),
      .wr_data (wr_data),
      .rd_en   (rd_accept),
      .rd_addr (rd_ptr_q[RD_DEPTH_WIDTH-1:0]),
      .rd_data (ram_rd_data)
   );

   assign rd_data        = ram_rd_data;
   assign wr_water_level = wr_lvl_q;
   assign rd_water_level = rd_lvl_q;
   assign wr_full        = flags_q.wr_full;
   assign almost_full    = flags_q.almost_full;
   assign rd_empty       = flags_q.rd_empty;
   assign almost_empty   = flags_q.almost_empty;

endmodule

// File: tb/tb_fifo_16i_64o_w1024.sv
// Directed bench for fifo_16i_64o_w1024: reset, packing order, fill/drain
// boundaries, steady-state streaming and mid-operation reset.
module tb_fifo_16i_64o_w1024;

   logic        clk = 1'b0;
   logic        wr_rst, rd_rst;
   logic [15:0] wr_data;
   logic        wr_en, rd_en;
   logic        wr_full, almost_full, rd_empty, almost_empty;
   logic [10:0] wr_water_level;
   logic [8:0]  rd_water_level;
   logic [63:0] rd_data;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   fifo_16i_64o_w1024 dut (
      .wr_clk         (clk),
      .wr_rst         (wr_rst),
      .rd_clk         (clk),
      .rd_rst         (rd_rst),
      .wr_data        (wr_data),
      .wr_en          (wr_en),
      .wr_full        (wr_full),
      .wr_water_level (wr_water_level),
      .almost_full    (almost_full),
      .rd_data        (rd_data),
      .rd_en          (rd_en),
      .rd_empty       (rd_empty),
      .rd_water_level (rd_water_level),
      .almost_empty   (almost_empty)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // all levels and flags for a stored count of lvl write words
   task automatic chk_state(input string tag, input int lvl);
      chk({tag, ".wr_lvl"}, 64'(wr_water_level), 64'(lvl));
      chk({tag, ".rd_lvl"}, 64'(rd_water_level), 64'(lvl / 4));
      chk({tag, ".full"},   64'(wr_full),        64'(lvl == 1024));
      chk({tag, ".afull"},  64'(almost_full),    64'(lvl >= 1020));
      chk({tag, ".empty"},  64'(rd_empty),       64'(lvl < 4));
      chk({tag, ".aempty"}, 64'(almost_empty),   64'((lvl / 4) <= 4));
   endtask

   // k-th read word of the decrementing fill
   function automatic logic [63:0] fill_word(input int k);
      logic [15:0] b;
      b = 16'hFFFF - 16'(4 * k);
      return {b - 16'd3, b - 16'd2, b - 16'd1, b};
   endfunction

   // j-th read word of the incrementing sequence
   function automatic logic [63:0] seq_word(input int j);
      return {16'(4 * j + 3), 16'(4 * j + 2), 16'(4 * j + 1), 16'(4 * j)};
   endfunction

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lvl;
      int seq;
      int j;
      logic [15:0] pat [4];

      wr_rst = 1'b1; rd_rst = 1'b1;
      wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
      tick(); tick();
      wr_rst = 1'b0; rd_rst = 1'b0;

      // reset state
      chk_state("reset", 0);
      chk("reset.rd_data", rd_data, 64'h0);

      // four writes form one read word, little-endian lanes
      pat[0] = 16'hFFFF; pat[1] = 16'hFFFE; pat[2] = 16'hFFFD; pat[3] = 16'hFFFC;
      for (int i = 0; i < 4; i++) begin
         wr_en = 1'b1; wr_data = pat[i];
         tick();
         chk_state("pack", i + 1);
      end
      wr_en = 1'b0; rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      chk("pack.rd_data", rd_data, 64'hFFFC_FFFD_FFFE_FFFF);
      chk_state("pack.after_rd", 0);

      // read while empty: ignored, rd_data holds
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      chk("empty_rd.rd_data", rd_data, 64'hFFFC_FFFD_FFFE_FFFF);
      chk_state("empty_rd", 0);

      // 1025 writes; the last one hits a full FIFO and is dropped
      for (int i = 0; i < 1025; i++) begin
         wr_en = 1'b1; wr_data = 16'hFFFF - 16'(i);
         tick();
         chk_state("fill", (i < 1024) ? i + 1 : 1024);
      end
      wr_en = 1'b0;

      // 257 reads; the last one hits an empty FIFO
      for (int k = 0; k < 257; k++) begin
         rd_en = 1'b1;
         tick();
         chk("drain.rd_data", rd_data, fill_word((k < 256) ? k : 255));
         chk_state("drain", (k < 256) ? 1024 - 4 * (k + 1) : 0);
      end
      rd_en = 1'b0;

      // steady state: preload 8, then one write per cycle, one read every 4th
      seq = 0;
      for (int i = 0; i < 8; i++) begin
         wr_en = 1'b1; wr_data = 16'(seq); seq++;
         tick();
         chk_state("preload", i + 1);
      end
      lvl = 8; j = 0;
      for (int c = 0; c < 16; c++) begin
         wr_en = 1'b1; wr_data = 16'(seq); seq++;
         rd_en = ((c % 4) == 0);
         tick();
         lvl = lvl + 1 - (((c % 4) == 0) ? 4 : 0);
         chk_state("steady", lvl);
         if ((c % 4) == 0) begin
            chk("steady.rd_data", rd_data, seq_word(j));
            j++;
         end
      end
      rd_en = 1'b0;
      chk_state("steady.end", 8);

      // fill to 500, then reset asynchronously in the middle of a cycle
      for (int i = 0; i < 492; i++) begin
         wr_en = 1'b1; wr_data = 16'(seq); seq++;
         tick();
      end
      wr_en = 1'b0;
      chk_state("lvl500", 500);
      #2 wr_rst = 1'b1;
      #1;
      chk_state("wr_rst.async", 0);
      chk("wr_rst.rd_data", rd_data, 64'h0);
      tick();
      #1 wr_rst = 1'b0;

      pat[0] = 16'h1111; pat[1] = 16'h2222; pat[2] = 16'h3333; pat[3] = 16'h4444;
      for (int i = 0; i < 4; i++) begin
         wr_en = 1'b1; wr_data = pat[i];
         tick();
         chk_state("post_rst", i + 1);
      end
      wr_en = 1'b0; rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      chk("post_rst.rd_data", rd_data, 64'h4444_3333_2222_1111);
      chk_state("post_rst.rd", 0);

      // read-side reset also clears everything
      for (int i = 0; i < 6; i++) begin
         wr_en = 1'b1; wr_data = 16'hABC0 + 16'(i);
         tick();
      end
      wr_en = 1'b0;
      chk_state("pre_rd_rst", 6);
      #2 rd_rst = 1'b1;
      #1;
      chk_state("rd_rst.async", 0);
      chk("rd_rst.rd_data", rd_data, 64'h0);
      tick();
      #1 rd_rst = 1'b0;
      pat[0] = 16'h0A0A; pat[1] = 16'h0B0B; pat[2] = 16'h0C0C; pat[3] = 16'h0D0D;
      for (int i = 0; i < 4; i++) begin
         wr_en = 1'b1; wr_data = pat[i];
         tick();
      end
      wr_en = 1'b0; rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      chk("post_rd_rst.rd_data", rd_data, 64'h0D0D_0C0C_0B0B_0A0A);
      chk_state("post_rd_rst", 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
